// File: rtl/fft_mem_responder.sv
// rtl/fft_mem_responder.sv - memory-side responder: request FIFOs, line RAM, throttled in-order read/write responses
module fft_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MDATA_WIDTH   = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 4,
  parameter int READ_LATENCY  = 4,
  parameter int RD_INTERVAL   = 1,
  parameter int WR_INTERVAL   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   c0_req_valid,
  input  logic [41:0]            c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  input  logic                   c1_req_valid,
  input  logic [41:0]            c1_req_addr,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  input  logic [511:0]           c1_req_data,
  output logic                   c0_almfull,
  output logic                   c1_almfull,
  output logic                   c0_rsp_valid,
  output logic [511:0]           c0_rsp_data,
  output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
  output logic                   c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
  output logic [1:0]             overflow_err
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  // The RAM output register is pipeline stage 0, so READ_LATENCY-1 stages follow the pop cycle.
  localparam int PIPE = READ_LATENCY - 1;
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALM_TH    = CW'(FIFO_DEPTH - ALMFULL_SLACK);
  localparam logic [15:0]   RD_RELOAD = 16'(RD_INTERVAL - 1);
  localparam logic [15:0]   WR_RELOAD = 16'(WR_INTERVAL - 1);

  logic [511:0]           r_mem [0:(2**ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0]  r_rq_addr [0:FIFO_DEPTH-1];
  logic [MDATA_WIDTH-1:0] r_rq_md   [0:FIFO_DEPTH-1];
  logic [PW-1:0]          r_rq_wp, r_rq_rp;
  logic [CW-1:0]          r_rq_cnt;
  logic [15:0]            r_rd_wait;

  logic [ADDR_WIDTH-1:0]  r_wq_addr [0:FIFO_DEPTH-1];
  logic [MDATA_WIDTH-1:0] r_wq_md   [0:FIFO_DEPTH-1];
  logic [511:0]           r_wq_data [0:FIFO_DEPTH-1];
  logic [PW-1:0]          r_wq_wp, r_wq_rp;
  logic [CW-1:0]          r_wq_cnt;
  logic [15:0]            r_wr_wait;

  logic                   r_pv  [0:PIPE-1];
  logic [MDATA_WIDTH-1:0] r_pmd [0:PIPE-1];
  logic [511:0]           r_pd  [0:PIPE-1];

  logic                   r_c0_almfull, r_c1_almfull;
  logic                   r_c1_rsp_valid;
  logic [MDATA_WIDTH-1:0] r_c1_rsp_mdata;
  logic [1:0]             r_overflow;

  logic                   w_rq_push, w_rq_pop, w_wq_push, w_wq_pop;
  logic [CW-1:0]          w_rq_cnt_nxt, w_wq_cnt_nxt;
  logic                   w_unused;

  // Overflow is judged on the pre-pop count: a full FIFO refuses even if it pops this cycle.
  assign w_rq_push    = c0_req_valid && (r_rq_cnt != FULL);
  assign w_rq_pop     = (r_rq_cnt != '0) && (r_rd_wait == 16'd0);
  assign w_rq_cnt_nxt = r_rq_cnt + CW'(w_rq_push) - CW'(w_rq_pop);
  assign w_wq_push    = c1_req_valid && (r_wq_cnt != FULL);
  assign w_wq_pop     = (r_wq_cnt != '0) && (r_wr_wait == 16'd0);
  assign w_wq_cnt_nxt = r_wq_cnt + CW'(w_wq_push) - CW'(w_wq_pop);

  // Address bits above the RAM index alias onto the same line.
  assign w_unused = ^{c0_req_addr[41:ADDR_WIDTH], c1_req_addr[41:ADDR_WIDTH]};

  // Request FIFO payload storage (no reset needed; pointers guard validity).
  always_ff @(posedge clk) begin
    if (w_rq_push) begin
      r_rq_addr[r_rq_wp] <= c0_req_addr[ADDR_WIDTH-1:0];
      r_rq_md[r_rq_wp]   <= c0_req_mdata;
    end
    if (w_wq_push) begin
      r_wq_addr[r_wq_wp] <= c1_req_addr[ADDR_WIDTH-1:0];
      r_wq_md[r_wq_wp]   <= c1_req_mdata;
      r_wq_data[r_wq_wp] <= c1_req_data;
    end
  end

  // FIFO pointers/counts, service throttles, registered almfull and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rq_wp <= '0; r_rq_rp <= '0; r_rq_cnt <= '0; r_rd_wait <= '0;
      r_wq_wp <= '0; r_wq_rp <= '0; r_wq_cnt <= '0; r_wr_wait <= '0;
      r_c0_almfull <= 1'b0;
      r_c1_almfull <= 1'b0;
      r_overflow   <= 2'b00;
    end else begin
      if (w_rq_push) r_rq_wp <= r_rq_wp + PW'(1);
      if (w_rq_pop)  r_rq_rp <= r_rq_rp + PW'(1);
      r_rq_cnt <= w_rq_cnt_nxt;
      if (w_rq_pop)                r_rd_wait <= RD_RELOAD;
      else if (r_rd_wait != 16'd0) r_rd_wait <= r_rd_wait - 16'd1;

      if (w_wq_push) r_wq_wp <= r_wq_wp + PW'(1);
      if (w_wq_pop)  r_wq_rp <= r_wq_rp + PW'(1);
      r_wq_cnt <= w_wq_cnt_nxt;
      if (w_wq_pop)                r_wr_wait <= WR_RELOAD;
      else if (r_wr_wait != 16'd0) r_wr_wait <= r_wr_wait - 16'd1;

      r_c0_almfull <= (w_rq_cnt_nxt >= ALM_TH);
      r_c1_almfull <= (w_wq_cnt_nxt >= ALM_TH);
      if (c0_req_valid && (r_rq_cnt == FULL)) r_overflow[0] <= 1'b1;
      if (c1_req_valid && (r_wq_cnt == FULL)) r_overflow[1] <= 1'b1;
    end
  end

  // Write commit happens in the pop cycle; a read popped in the same cycle sees the old line.
  always_ff @(posedge clk) begin
    if (w_wq_pop) r_mem[r_wq_addr[r_wq_rp]] <= r_wq_data[r_wq_rp];
  end

  // Read data path: stage 0 captures the RAM line, later stages only delay it.
  always_ff @(posedge clk) begin
    if (w_rq_pop) r_pd[0] <= r_mem[r_rq_addr[r_rq_rp]];
    for (int k = 1; k < PIPE; k++) r_pd[k] <= r_pd[k-1];
  end

  // Read valid/tag pipeline; cleared by reset so no pre-reset response escapes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < PIPE; k++) begin
        r_pv[k]  <= 1'b0;
        r_pmd[k] <= '0;
      end
    end else begin
      r_pv[0]  <= w_rq_pop;
      r_pmd[0] <= w_rq_pop ? r_rq_md[r_rq_rp] : '0;
      for (int k = 1; k < PIPE; k++) begin
        r_pv[k]  <= r_pv[k-1];
        r_pmd[k] <= r_pmd[k-1];
      end
    end
  end

  // Write ack one cycle after commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c1_rsp_valid <= 1'b0;
      r_c1_rsp_mdata <= '0;
    end else begin
      r_c1_rsp_valid <= w_wq_pop;
      r_c1_rsp_mdata <= w_wq_pop ? r_wq_md[r_wq_rp] : '0;
    end
  end

  assign c0_almfull   = r_c0_almfull;
  assign c1_almfull   = r_c1_almfull;
  assign c0_rsp_valid = r_pv[PIPE-1];
  assign c0_rsp_mdata = r_pmd[PIPE-1];
  // The data stages carry no reset, so gate them to keep the bus at 0 when idle or in reset.
  assign c0_rsp_data  = r_pv[PIPE-1] ? r_pd[PIPE-1] : '0;
  assign c1_rsp_valid = r_c1_rsp_valid;
  assign c1_rsp_mdata = r_c1_rsp_mdata;
  assign overflow_err = r_overflow;
endmodule

// File: tb/tb_fft_mem_responder.sv
// tb/tb_fft_mem_responder.sv - directed table-driven bench for fft_mem_responder
module tb_fft_mem_responder;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         c0_req_valid, c1_req_valid;
  logic [41:0]  c0_req_addr, c1_req_addr;
  logic [15:0]  c0_req_mdata, c1_req_mdata;
  logic [511:0] c1_req_data;

  // a: defaults, b: RD_INTERVAL=3, c: RD_INTERVAL=16; all share the request inputs
  logic         a_c0_almfull, a_c1_almfull, a_c0_rsp_valid, a_c1_rsp_valid;
  logic [511:0] a_c0_rsp_data;
  logic [15:0]  a_c0_rsp_mdata, a_c1_rsp_mdata;
  logic [1:0]   a_overflow_err;
  logic         b_c0_almfull, b_c1_almfull, b_c0_rsp_valid, b_c1_rsp_valid;
  logic [511:0] b_c0_rsp_data;
  logic [15:0]  b_c0_rsp_mdata, b_c1_rsp_mdata;
  logic [1:0]   b_overflow_err;
  logic         c_c0_almfull, c_c1_almfull, c_c0_rsp_valid, c_c1_rsp_valid;
  logic [511:0] c_c0_rsp_data;
  logic [15:0]  c_c0_rsp_mdata, c_c1_rsp_mdata;
  logic [1:0]   c_overflow_err;

  fft_mem_responder u_a (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data), .c0_almfull(a_c0_almfull), .c1_almfull(a_c1_almfull),
    .c0_rsp_valid(a_c0_rsp_valid), .c0_rsp_data(a_c0_rsp_data), .c0_rsp_mdata(a_c0_rsp_mdata),
    .c1_rsp_valid(a_c1_rsp_valid), .c1_rsp_mdata(a_c1_rsp_mdata), .overflow_err(a_overflow_err));

  fft_mem_responder #(.RD_INTERVAL(3)) u_b (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data), .c0_almfull(b_c0_almfull), .c1_almfull(b_c1_almfull),
    .c0_rsp_valid(b_c0_rsp_valid), .c0_rsp_data(b_c0_rsp_data), .c0_rsp_mdata(b_c0_rsp_mdata),
    .c1_rsp_valid(b_c1_rsp_valid), .c1_rsp_mdata(b_c1_rsp_mdata), .overflow_err(b_overflow_err));

  fft_mem_responder #(.RD_INTERVAL(16)) u_c (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data), .c0_almfull(c_c0_almfull), .c1_almfull(c_c1_almfull),
    .c0_rsp_valid(c_c0_rsp_valid), .c0_rsp_data(c_c0_rsp_data), .c0_rsp_mdata(c_c0_rsp_mdata),
    .c1_rsp_valid(c_c1_rsp_valid), .c1_rsp_mdata(c_c1_rsp_mdata), .overflow_err(c_overflow_err));

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [15:0]  md;
    logic [511:0] d;
  } rsp_t;

  typedef struct {
    logic [41:0]  wa;
    logic [511:0] wd;
    logic [15:0]  wm;
    logic [41:0]  ra;
    logic [15:0]  rm;
    logic [511:0] ed;
  } vec_t;

  rsp_t qa0[$], qa1[$], qb0[$], qc0[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic alm_c_hist [0:8191];
  logic alm_a_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every response with the cycle it is visible in.
  always @(negedge clk) begin
    rsp_t r;
    if (a_c0_rsp_valid) begin r.cyc = cyc; r.md = a_c0_rsp_mdata; r.d = a_c0_rsp_data; qa0.push_back(r); end
    if (a_c1_rsp_valid) begin r.cyc = cyc; r.md = a_c1_rsp_mdata; r.d = '0; qa1.push_back(r); end
    if (b_c0_rsp_valid) begin r.cyc = cyc; r.md = b_c0_rsp_mdata; r.d = b_c0_rsp_data; qb0.push_back(r); end
    if (c_c0_rsp_valid) begin r.cyc = cyc; r.md = c_c0_rsp_mdata; r.d = c_c0_rsp_data; qc0.push_back(r); end
    if (cyc < 8192) alm_c_hist[cyc] = c_c0_almfull;
    if (a_c0_almfull) alm_a_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // which: 0=a read, 1=a write ack, 2=b read, 3=c read
  task automatic chk_q(input string tag, input int which, input int idx, input int ecyc,
                       input logic [15:0] emd, input logic [511:0] ed, input bit use_d);
    rsp_t r;
    int   sz;
    case (which)
      0: sz = qa0.size();
      1: sz = qa1.size();
      2: sz = qb0.size();
      default: sz = qc0.size();
    endcase
    if (idx >= sz) begin
      checks++; errors++;
      $display("FAIL %s[%0d]: response missing, only %0d logged", tag, idx, sz);
      return;
    end
    case (which)
      0: r = qa0[idx];
      1: r = qa1[idx];
      2: r = qb0[idx];
      default: r = qc0[idx];
    endcase
    chk($sformatf("%s[%0d].cycle", tag, idx), 512'(r.cyc), 512'(ecyc));
    chk($sformatf("%s[%0d].mdata", tag, idx), 512'(r.md), 512'(emd));
    if (use_d) chk($sformatf("%s[%0d].data", tag, idx), r.d, ed);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_q();
    qa0.delete(); qa1.delete(); qb0.delete(); qc0.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    clear_q();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t         vt [0:5];
    logic [511:0] p0, p1, p2, p3, p4, p5, pa, pb;
    int           t;

    p0 = {16{32'hA5A5_0001}};
    p1 = {8{64'h0123_4567_89AB_CDEF}};
    p2 = '1;
    p3 = {16{32'hDEAD_0007}};
    p4 = {16{32'h5A5A_FFFE}};
    p5 = {64{8'h3C}};
    pa = {16{32'h0000_0A03}};
    pb = {16{32'h1111_0B03}};
    vt[0] = '{42'h5,   p0, 16'h0011, 42'h5,   16'h0022, p0};
    vt[1] = '{42'h3FF, p1, 16'hBEEF, 42'h3FF, 16'h1234, p1};
    vt[2] = '{42'h0,   p2, 16'h0000, 42'h400, 16'hFFFF, p2};
    vt[3] = '{42'h2AA_AAAA_A807, p3, 16'h0007, 42'h7, 16'h0777, p3};
    vt[4] = '{42'h5,   p4, 16'h0044, 42'h5,   16'h0055, p4};
    vt[5] = '{42'h6,   p5, 16'h0066, 42'h3FF, 16'h0077, p1};

    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_req_mdata = '0; c1_req_data = '0;
    alm_a_seen = 1'b0;
    reset_n = 1'b0;
    idle(2);
    chk("reset.outputs", 512'({a_c0_almfull, a_c1_almfull, a_c0_rsp_valid, a_c1_rsp_valid,
                               a_c0_rsp_mdata, a_c1_rsp_mdata, a_overflow_err}), 512'(0));
    chk("reset.c0_rsp_data", a_c0_rsp_data, '0);
    reset_n = 1'b1;
    idle(1);

    // write then read per row: ack at T+2, read issued T+3 returns at T+7
    for (int i = 0; i < 6; i++) begin
      clear_q();
      t = cyc;
      c1_req_valid = 1'b1; c1_req_addr = vt[i].wa; c1_req_mdata = vt[i].wm; c1_req_data = vt[i].wd;
      tick();
      c1_req_valid = 1'b0;
      idle(2);
      c0_req_valid = 1'b1; c0_req_addr = vt[i].ra; c0_req_mdata = vt[i].rm;
      tick();
      c0_req_valid = 1'b0;
      idle(8);
      chk($sformatf("vec%0d.ack_count", i), 512'(qa1.size()), 512'(1));
      chk_q($sformatf("vec%0d.ack", i), 1, 0, t + 2, vt[i].wm, '0, 1'b0);
      chk($sformatf("vec%0d.rsp_count", i), 512'(qa0.size()), 512'(1));
      chk_q($sformatf("vec%0d.rsp", i), 0, 0, t + 7, vt[i].rm, vt[i].ed, 1'b1);
    end

    // 8 back-to-back reads at interval 1: consecutive responses from T+4, FIFO never nears full
    do_reset();
    alm_a_seen = 1'b0;
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      c0_req_valid = 1'b1; c0_req_addr = 42'h5; c0_req_mdata = 16'h0100 + 16'(i);
      tick();
    end
    c0_req_valid = 1'b0;
    idle(12);
    chk("b2b.count", 512'(qa0.size()), 512'(8));
    for (int i = 0; i < 8; i++) chk_q("b2b", 0, i, t + 4 + i, 16'h0100 + 16'(i), p4, 1'b1);
    chk("b2b.almfull_seen", 512'(alm_a_seen), 512'(0));

    // RD_INTERVAL=3: responses at T+4, T+7, T+10
    do_reset();
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      c0_req_valid = 1'b1; c0_req_addr = 42'h5; c0_req_mdata = 16'h0031 + 16'(i);
      tick();
    end
    c0_req_valid = 1'b0;
    idle(14);
    chk("int3.count", 512'(qb0.size()), 512'(3));
    for (int i = 0; i < 3; i++) chk_q("int3", 2, i, t + 4 + 3 * i, 16'h0031 + 16'(i), p4, 1'b1);

    // RD_INTERVAL=16: 10 reads in 10 cycles; one pop at T+1 leaves room for 9, the 10th overflows
    do_reset();
    t = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("ovf.before_drop", 512'(c_overflow_err), 512'(2'b00));
      c0_req_valid = 1'b1; c0_req_addr = 42'h5; c0_req_mdata = 16'h0040 + 16'(i);
      tick();
    end
    c0_req_valid = 1'b0;
    chk("ovf.after_drop", 512'(c_overflow_err), 512'(2'b01));
    chk("ovf.interval1_no_drop", 512'(a_overflow_err), 512'(2'b00));
    idle(140);
    chk("ovf.sticky", 512'(c_overflow_err), 512'(2'b01));
    chk("ovf.count", 512'(qc0.size()), 512'(9));
    for (int i = 0; i < 9; i++) chk_q("ovf", 3, i, t + 4 + 16 * i, 16'h0040 + 16'(i), p4, 1'b1);
    chk("alm.T+4", 512'(alm_c_hist[t + 4]), 512'(0));
    chk("alm.T+5", 512'(alm_c_hist[t + 5]), 512'(1));
    chk("alm.T+81", 512'(alm_c_hist[t + 81]), 512'(1));
    chk("alm.T+82", 512'(alm_c_hist[t + 82]), 512'(0));

    // reset with reads in flight: outputs drop asynchronously, nothing emerges afterwards
    for (int i = 0; i < 3; i++) begin
      c0_req_valid = 1'b1; c0_req_addr = 42'h5; c0_req_mdata = 16'h0060 + 16'(i);
      tick();
    end
    c0_req_valid = 1'b0;
    idle(2);
    chk("rst.pre_valid", 512'(a_c0_rsp_valid), 512'(1));
    #1 reset_n = 1'b0;
    #1;
    chk("rst.async_outputs", 512'({a_c0_almfull, a_c1_almfull, a_c0_rsp_valid, a_c1_rsp_valid,
                                   a_c0_rsp_mdata, a_c1_rsp_mdata, a_overflow_err}), 512'(0));
    chk("rst.async_data", a_c0_rsp_data, '0);
    chk("rst.ovf_cleared", 512'(c_overflow_err), 512'(2'b00));
    idle(2);
    reset_n = 1'b1;
    clear_q();
    idle(10);
    chk("rst.no_stale_rsp", 512'(qa0.size() + qb0.size() + qc0.size()), 512'(0));
    chk("rst.almfull", 512'({a_c0_almfull, c_c0_almfull}), 512'(0));

    // same-cycle commit and alias read see old data; read one cycle later sees new data
    c1_req_valid = 1'b1; c1_req_addr = 42'h3; c1_req_mdata = 16'h0081; c1_req_data = pa;
    tick();
    c1_req_valid = 1'b0;
    idle(3);
    clear_q();
    t = cyc;
    c0_req_valid = 1'b1; c0_req_addr = 42'h403; c0_req_mdata = 16'h0091;
    c1_req_valid = 1'b1; c1_req_addr = 42'h3; c1_req_mdata = 16'h0082; c1_req_data = pb;
    tick();
    c1_req_valid = 1'b0;
    c0_req_addr = 42'h3; c0_req_mdata = 16'h0092;
    tick();
    c0_req_valid = 1'b0;
    idle(8);
    chk("raw.count", 512'(qa0.size()), 512'(2));
    chk_q("raw.old", 0, 0, t + 4, 16'h0091, pa, 1'b1);
    chk_q("raw.new", 0, 1, t + 5, 16'h0092, pb, 1'b1);
    chk_q("raw.ack", 1, 0, t + 2, 16'h0082, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
